// File: rtl/ewb_drain.sv
// Drains eviction-write-buffer lines to memory as 64-bit beats and serves L2 fill reads.
// Optional build macro EWB_DRAIN_FULL_PRIO_EN lets a full buffer win IDLE arbitration over a read.
module ewb_drain #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ewb_empty_i,
  input  logic         ewb_full_i,
  input  logic [255:0] ewb_data_i,
  input  logic [31:0]  ewb_addr_i,
  output logic         ewb_yumi_o,
  input  logic         rd_req_i,
  input  logic [31:0]  rd_addr_i,
  output logic [255:0] rd_data_o,
  output logic         rd_done_o,
  output logic [31:0]  pmem_addr_o,
  output logic         pmem_read_o,
  output logic         pmem_write_o,
  output logic [63:0]  pmem_wdata_o,
  input  logic [63:0]  pmem_rdata_i,
  input  logic         pmem_resp_i
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    WR_DONE  = 3'd2,
    RD_BURST = 3'd3,
    RD_DONE  = 3'd4
  } state_e;

  state_e         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [255:0]   line_r, line_s;
  logic [255:0]   rdata_s;
  logic [26:0]    waddr_r, waddr_s;
  logic           full_prio_s;
  logic           addr_unused_s;

  // Line offset bits never reach memory; addresses are always line aligned.
  assign addr_unused_s = ^{ewb_addr_i[4:0], rd_addr_i[4:0]};

`ifdef EWB_DRAIN_FULL_PRIO_EN
  assign full_prio_s = ewb_full_i & ~ewb_empty_i;
`else
  logic full_unused_s;
  assign full_unused_s = ewb_full_i;
  assign full_prio_s   = 1'b0;
`endif

  // Next-state, beat counter, write-line latch and fill-line assembly.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    line_s  = line_r;
    waddr_s = waddr_r;
    rdata_s = rd_data_o;
    case (state_r)
      IDLE: begin
        if (full_prio_s || (!rd_req_i && !ewb_empty_i)) begin
          state_s = WR_BURST;
          cnt_s   = {CW{1'b0}};
          line_s  = ewb_data_i;
          waddr_s = ewb_addr_i[31:5];
        end else if (rd_req_i) begin
          state_s = RD_BURST;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      WR_BURST: begin
        if (pmem_resp_i) begin
          if (cnt_r == LAST_BEAT) begin
            cnt_s   = {CW{1'b0}};
            state_s = WR_DONE;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      WR_DONE: state_s = IDLE;
      RD_BURST: begin
        if (pmem_resp_i) begin
          rdata_s[{cnt_r, 6'd0} +: 64] = pmem_rdata_i;
          if (cnt_r == LAST_BEAT) begin
            cnt_s   = {CW{1'b0}};
            state_s = RD_DONE;
          end else begin
            cnt_s = cnt_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      RD_DONE: state_s = IDLE;
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      line_r       <= 256'd0;
      waddr_r      <= 27'd0;
      rd_data_o    <= 256'd0;
      pmem_write_o <= 1'b0;
      pmem_read_o  <= 1'b0;
      ewb_yumi_o   <= 1'b0;
      rd_done_o    <= 1'b0;
      pmem_wdata_o <= 64'd0;
      pmem_addr_o  <= 32'd0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      line_r       <= line_s;
      waddr_r      <= waddr_s;
      rd_data_o    <= rdata_s;
      pmem_write_o <= (state_s == WR_BURST);
      pmem_read_o  <= (state_s == RD_BURST);
      ewb_yumi_o   <= (state_s == WR_DONE);
      rd_done_o    <= (state_s == RD_DONE);
      pmem_wdata_o <= line_s[{cnt_s, 6'd0} +: 64];
      pmem_addr_o  <= (state_s == RD_BURST) ? {rd_addr_i[31:5], 5'd0} : {waddr_s, 5'd0};
    end
  end

endmodule

// File: tb/tb_ewb_drain.sv
// Scoreboard bench for ewb_drain: expected write beats and fill lines are queued when driven.
module tb_ewb_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         ewb_empty_i, ewb_full_i, ewb_yumi_o;
  logic [255:0] ewb_data_i, rd_data_o;
  logic [31:0]  ewb_addr_i, rd_addr_i, pmem_addr_o;
  logic         rd_req_i, rd_done_o, pmem_read_o, pmem_write_o, pmem_resp_i;
  logic [63:0]  pmem_wdata_o, pmem_rdata_i;

  ewb_drain #(.BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .ewb_empty_i(ewb_empty_i), .ewb_full_i(ewb_full_i), .ewb_data_i(ewb_data_i),
    .ewb_addr_i(ewb_addr_i), .ewb_yumi_o(ewb_yumi_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_done_o(rd_done_o),
    .pmem_addr_o(pmem_addr_o), .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o),
    .pmem_wdata_o(pmem_wdata_o), .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic [63:0]  exp_w[$];
  logic [63:0]  obs_w[$];
  logic [255:0] exp_rd[$];
  logic [63:0]  rd_beats[4];
  int rk, yumi_cnt, yumi_cyc, done_cnt, done_cyc, w_first, r_first, overlap_cnt;
  logic [31:0]  w_addr, r_addr;
  logic [63:0]  exp_b, obs_b;
  logic [255:0] exp_line;

  task clear_obs;
    obs_w.delete();
    rk = 0; yumi_cnt = 0; yumi_cyc = -1; done_cnt = 0; done_cyc = -1;
    w_first = -1; r_first = -1; overlap_cnt = 0; w_addr = '0; r_addr = '0;
  endtask

  // Record this cycle (inputs are final), advance one clock, then react like buffer/requester/memory.
  task step;
    if (pmem_write_o === 1'b1 && pmem_resp_i) obs_w.push_back(pmem_wdata_o);
    if (pmem_write_o === 1'b1 && w_first < 0) begin w_first = cyc; w_addr = pmem_addr_o; end
    if (pmem_read_o === 1'b1 && r_first < 0) begin r_first = cyc; r_addr = pmem_addr_o; end
    if (pmem_write_o === 1'b1 && pmem_read_o === 1'b1) overlap_cnt++;
    if (ewb_yumi_o === 1'b1) begin yumi_cnt++; yumi_cyc = cyc; end
    if (rd_done_o === 1'b1) begin done_cnt++; done_cyc = cyc; end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (ewb_yumi_o === 1'b1) ewb_empty_i = 1'b1;
    if (rd_done_o === 1'b1) rd_req_i = 1'b0;
    if (pmem_read_o === 1'b1) begin
      pmem_rdata_i = rd_beats[rk];
      if (rk < 3) rk++;
    end
  endtask

  // kind 0: yumi seen, 1: rd_done seen, 2: both seen
  task wait_for(input int kind, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (kind == 0 && yumi_cnt > 0) break;
      if (kind == 1 && done_cnt > 0) break;
      if (kind == 2 && yumi_cnt > 0 && done_cnt > 0) break;
      step();
    end
  endtask

  task test_reset;
    rst = 1'b1; ewb_empty_i = 1'b1; ewb_full_i = 1'b0; rd_req_i = 1'b0; pmem_resp_i = 1'b0;
    ewb_data_i = '0; ewb_addr_i = '0; rd_addr_i = '0; pmem_rdata_i = '0;
    clear_obs();
    #2 rst = 1'b0;
    ewb_empty_i = 1'b0; rd_req_i = 1'b1; pmem_resp_i = 1'b1;
    ewb_data_i = {4{64'hDEAD_BEEF_0BAD_F00D}};
    step(); step();
    vec_cnt++; if (pmem_write_o !== 1'b0) begin err_cnt++; $display("FAIL rst_write: got %b want 0", pmem_write_o); end
    vec_cnt++; if (pmem_read_o !== 1'b0) begin err_cnt++; $display("FAIL rst_read: got %b want 0", pmem_read_o); end
    vec_cnt++; if (ewb_yumi_o !== 1'b0) begin err_cnt++; $display("FAIL rst_yumi: got %b want 0", ewb_yumi_o); end
    vec_cnt++; if (rd_done_o !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b want 0", rd_done_o); end
    vec_cnt++; if (rd_data_o !== 256'd0) begin err_cnt++; $display("FAIL rst_rdata: got %h want 0", rd_data_o); end
    vec_cnt++; if (pmem_wdata_o !== 64'd0) begin err_cnt++; $display("FAIL rst_wdata: got %h want 0", pmem_wdata_o); end
    ewb_empty_i = 1'b1; rd_req_i = 1'b0; pmem_resp_i = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task test_idle_resp;
    clear_obs();
    exp_line = rd_data_o;
    pmem_resp_i = 1'b1;
    repeat (4) step();
    pmem_resp_i = 1'b0;
    vec_cnt++; if (w_first != -1 || r_first != -1) begin err_cnt++; $display("FAIL idle_strobe: got w=%0d r=%0d want -1", w_first, r_first); end
    vec_cnt++; if (yumi_cnt + done_cnt != 0) begin err_cnt++; $display("FAIL idle_pulse: got %0d want 0", yumi_cnt + done_cnt); end
    vec_cnt++; if (rd_data_o !== exp_line) begin err_cnt++; $display("FAIL idle_rdata: got %h want %h", rd_data_o, exp_line); end
  endtask

  task test_single_write;
    int c0;
    clear_obs();
    ewb_data_i = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    ewb_addr_i = 32'h0000_1234;
    exp_w.push_back(64'h1111_1111_1111_1111); exp_w.push_back(64'h2222_2222_2222_2222);
    exp_w.push_back(64'h3333_3333_3333_3333); exp_w.push_back(64'h4444_4444_4444_4444);
    c0 = cyc; ewb_empty_i = 1'b0; pmem_resp_i = 1'b1;
    step();
    ewb_data_i = ~ewb_data_i; ewb_addr_i = 32'hFFFF_FFFF;
    wait_for(0, 20); step(); step();
    pmem_resp_i = 1'b0;
    vec_cnt++; if (yumi_cnt != 1) begin err_cnt++; $display("FAIL wr_yumi_cnt: got %0d want 1", yumi_cnt); end
    vec_cnt++; if (yumi_cyc - c0 != 5) begin err_cnt++; $display("FAIL wr_latency: got %0d want 5", yumi_cyc - c0); end
    vec_cnt++; if (w_first - c0 != 1) begin err_cnt++; $display("FAIL wr_start: got %0d want 1", w_first - c0); end
    vec_cnt++; if (w_addr !== 32'h0000_1220) begin err_cnt++; $display("FAIL wr_addr: got %h want 00001220", w_addr); end
    while (exp_w.size() > 0) begin
      exp_b = exp_w.pop_front(); vec_cnt++;
      if (obs_w.size() == 0) begin err_cnt++; $display("FAIL wr_beat: got none want %h", exp_b); end
      else begin obs_b = obs_w.pop_front();
        if (obs_b !== exp_b) begin err_cnt++; $display("FAIL wr_beat: got %h want %h", obs_b, exp_b); end end
    end
    vec_cnt++; if (obs_w.size() != 0) begin err_cnt++; $display("FAIL wr_extra: got %0d extra beats want 0", obs_w.size()); end
  endtask

  task test_single_read;
    int c0;
    clear_obs();
    rd_beats[0] = 64'hAAAA_0000_0000_000A; rd_beats[1] = 64'hBBBB_0000_0000_000B;
    rd_beats[2] = 64'hCCCC_0000_0000_000C; rd_beats[3] = 64'hDDDD_0000_0000_000D;
    exp_rd.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
    rd_addr_i = 32'h0000_8040;
    c0 = cyc; rd_req_i = 1'b1; pmem_resp_i = 1'b1;
    wait_for(1, 20); step();
    exp_line = exp_rd.pop_front();
    vec_cnt++; if (rd_data_o !== exp_line) begin err_cnt++; $display("FAIL rd_line: got %h want %h", rd_data_o, exp_line); end
    pmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) step();
    pmem_resp_i = 1'b0;
    vec_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL rd_done_cnt: got %0d want 1", done_cnt); end
    vec_cnt++; if (done_cyc - c0 != 5) begin err_cnt++; $display("FAIL rd_latency: got %0d want 5", done_cyc - c0); end
    vec_cnt++; if (r_addr !== 32'h0000_8040) begin err_cnt++; $display("FAIL rd_addr: got %h want 00008040", r_addr); end
    vec_cnt++; if (rd_data_o !== exp_line) begin err_cnt++; $display("FAIL rd_hold: got %h want %h", rd_data_o, exp_line); end
  endtask

  task test_stall;
    int c0;
    clear_obs();
    ewb_data_i = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                  64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    ewb_addr_i = 32'h2000_0047;
    for (int i = 0; i < 4; i++) exp_w.push_back(ewb_data_i[i*64 +: 64]);
    c0 = cyc; ewb_empty_i = 1'b0; pmem_resp_i = 1'b1;
    step();
    for (int i = 0; i < 10 && obs_w.size() < 1; i++) step();
    pmem_resp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (pmem_write_o !== 1'b1 || pmem_wdata_o !== 64'hA1A1_0000_0000_0001) begin
        err_cnt++; $display("FAIL stall_hold: got wr=%b data=%h want 1/a1a1000000000001", pmem_write_o, pmem_wdata_o); end
      step();
    end
    vec_cnt++; if (yumi_cnt != 0) begin err_cnt++; $display("FAIL stall_early_yumi: got %0d want 0", yumi_cnt); end
    pmem_resp_i = 1'b1;
    wait_for(0, 20); step();
    pmem_resp_i = 1'b0;
    vec_cnt++; if (yumi_cyc - c0 != 8) begin err_cnt++; $display("FAIL stall_latency: got %0d want 8", yumi_cyc - c0); end
    vec_cnt++; if (w_addr !== 32'h2000_0040) begin err_cnt++; $display("FAIL stall_addr: got %h want 20000040", w_addr); end
    while (exp_w.size() > 0) begin
      exp_b = exp_w.pop_front(); vec_cnt++;
      if (obs_w.size() == 0) begin err_cnt++; $display("FAIL stall_beat: got none want %h", exp_b); end
      else begin obs_b = obs_w.pop_front();
        if (obs_b !== exp_b) begin err_cnt++; $display("FAIL stall_beat: got %h want %h", obs_b, exp_b); end end
    end
  endtask

  task test_arbitration(input logic full);
    int c0, ew, ey, er, ed;
    logic wf;
    clear_obs();
`ifdef EWB_DRAIN_FULL_PRIO_EN
    wf = full;
`else
    wf = 1'b0;
`endif
    rd_beats[0] = 64'h0101_0101_0000_0000 ^ {63'd0, full}; rd_beats[1] = 64'h0202_0202_0000_0000;
    rd_beats[2] = 64'h0303_0303_0000_0000; rd_beats[3] = 64'h0404_0404_0000_0000;
    exp_rd.push_back({rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]});
    ewb_data_i = {64'hB3B3_0000_0000_0000, 64'hB2B2_0000_0000_0000,
                  64'hB1B1_0000_0000_0000, 64'hB0B0_0000_0000_0000 ^ {63'd0, full}};
    for (int i = 0; i < 4; i++) exp_w.push_back(ewb_data_i[i*64 +: 64]);
    ewb_addr_i = 32'h0000_9000; rd_addr_i = 32'h0000_4000;
    ew = wf ? 1 : 7; ey = wf ? 5 : 11; er = wf ? 7 : 1; ed = wf ? 11 : 5;
    c0 = cyc; ewb_empty_i = 1'b0; ewb_full_i = full; rd_req_i = 1'b1; pmem_resp_i = 1'b1;
    wait_for(2, 40); step(); step();
    pmem_resp_i = 1'b0; ewb_full_i = 1'b0;
    vec_cnt++; if (w_first - c0 != ew) begin err_cnt++; $display("FAIL arb%0d_wr_start: got %0d want %0d", full, w_first - c0, ew); end
    vec_cnt++; if (yumi_cyc - c0 != ey) begin err_cnt++; $display("FAIL arb%0d_yumi: got %0d want %0d", full, yumi_cyc - c0, ey); end
    vec_cnt++; if (r_first - c0 != er) begin err_cnt++; $display("FAIL arb%0d_rd_start: got %0d want %0d", full, r_first - c0, er); end
    vec_cnt++; if (done_cyc - c0 != ed) begin err_cnt++; $display("FAIL arb%0d_done: got %0d want %0d", full, done_cyc - c0, ed); end
    vec_cnt++; if (overlap_cnt != 0) begin err_cnt++; $display("FAIL arb%0d_overlap: got %0d want 0", full, overlap_cnt); end
    exp_line = exp_rd.pop_front();
    vec_cnt++; if (rd_data_o !== exp_line) begin err_cnt++; $display("FAIL arb%0d_line: got %h want %h", full, rd_data_o, exp_line); end
    while (exp_w.size() > 0) begin
      exp_b = exp_w.pop_front(); vec_cnt++;
      if (obs_w.size() == 0) begin err_cnt++; $display("FAIL arb_beat: got none want %h", exp_b); end
      else begin obs_b = obs_w.pop_front();
        if (obs_b !== exp_b) begin err_cnt++; $display("FAIL arb_beat: got %h want %h", obs_b, exp_b); end end
    end
  endtask

  task test_reset_mid_burst;
    int c0;
    clear_obs();
    ewb_data_i = {64'hE3E3_0000_0000_0000, 64'hE2E2_0000_0000_0000,
                  64'hE1E1_0000_0000_0000, 64'hE0E0_0000_0000_0000};
    ewb_addr_i = 32'h0000_5500;
    ewb_empty_i = 1'b0; pmem_resp_i = 1'b1;
    step();
    for (int i = 0; i < 10 && obs_w.size() < 2; i++) step();
    rst = 1'b0;
    #1;
    vec_cnt++; if (pmem_write_o !== 1'b0 || pmem_read_o !== 1'b0) begin
      err_cnt++; $display("FAIL abort_strobes: got wr=%b rd=%b want 0/0", pmem_write_o, pmem_read_o); end
    step(); step();
    rst = 1'b1;
    obs_w.delete();
    for (int i = 0; i < 4; i++) exp_w.push_back(ewb_data_i[i*64 +: 64]);
    c0 = cyc;
    wait_for(0, 20); step();
    pmem_resp_i = 1'b0;
    vec_cnt++; if (yumi_cnt != 1) begin err_cnt++; $display("FAIL abort_yumi_cnt: got %0d want 1", yumi_cnt); end
    vec_cnt++; if (yumi_cyc - c0 != 5) begin err_cnt++; $display("FAIL abort_redrain: got %0d want 5", yumi_cyc - c0); end
    while (exp_w.size() > 0) begin
      exp_b = exp_w.pop_front(); vec_cnt++;
      if (obs_w.size() == 0) begin err_cnt++; $display("FAIL abort_beat: got none want %h", exp_b); end
      else begin obs_b = obs_w.pop_front();
        if (obs_b !== exp_b) begin err_cnt++; $display("FAIL abort_beat: got %h want %h", obs_b, exp_b); end end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_idle_resp();
    test_stall();
    test_arbitration(1'b0);
    test_arbitration(1'b1);
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
